// File: rtl/icmp_pkg.sv
// rtl/icmp_pkg.sv - shared constants, state encoding and checksum helpers for the ICMP echo responder
package icmp_pkg;

   localparam logic [7:0] ICMP_PROTO      = 8'd1;
   localparam logic [7:0] ICMP_ECHO_REQ   = 8'd8;
   localparam logic [7:0] ICMP_ECHO_REPLY = 8'd0;

   typedef enum logic [2:0] {
      IDLE,
      RX,
      RX_GAP,
      FIX,
      TX,
      TX_GAP
   } state_t;

   // 16-bit ones-complement add; a single end-around carry cannot overflow again
   function automatic logic [15:0] oc_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

   // Converts between bus byte order (first byte low) and network order
   function automatic logic [15:0] swap16(input logic [15:0] w);
      return {w[7:0], w[15:8]};
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

endpackage

// File: rtl/icmp_echo_buf.sv
// rtl/icmp_echo_buf.sv - payload buffer, one write port and one registered read port
module icmp_echo_buf #(
   parameter int BUF_WORDS = 256,
   parameter int AW        = 8
) (
   input  logic          wb_clk_i,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [15:0]   wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [15:0]   rd_data
);

   logic [15:0] mem [0:BUF_WORDS-1];

   // Synchronous write and registered read; no reset so it maps onto block RAM
   always_ff @(posedge wb_clk_i) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/icmp_echo_responder.sv
// rtl/icmp_echo_responder.sv - answers ICMP echo requests over the IP layer Wishbone port; ICMP_CSUM_VERIFY_EN adds receive checksum checking
module icmp_echo_responder #(
   parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0102,
   parameter int          BUF_WORDS = 256,
   parameter int          AW        = 8
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        enable_i,
   output logic        ip_wb_cyc_o,
   output logic        ip_wb_stb_o,
   output logic        ip_wb_we_o,
   input  logic        ip_wb_ack_i,
   input  logic        ip_wb_rty_i,
   output logic [15:0] ip_wb_dat_o,
   input  logic [15:0] ip_wb_dat_i,
   input  logic [31:0] rx_src_ip_i,
   input  logic [31:0] rx_dest_ip_i,
   input  logic [7:0]  rx_protocol_i,
   input  logic [15:0] rx_length_i,
   output logic [31:0] tx_src_ip_o,
   output logic [31:0] tx_dest_ip_o,
   output logic [7:0]  tx_protocol_o,
   output logic [15:0] tx_length_o,
   output logic [15:0] rx_count_o,
   output logic [15:0] tx_count_o,
   output logic [15:0] drop_count_o
);

   import icmp_pkg::*;

   state_t      state;
   logic [15:0] wcnt;
   logic [15:0] ridx;
   logic [15:0] len_q;
   logic [31:0] src_q;
   logic        drop_q;
   logic [15:0] w0_q;
   logic [15:0] w1_q;

   logic        rx_acc;
   logic        tx_acc;
   logic        first_word;
   logic        bad_meta;
   logic        drop_now;
   logic [15:0] cur_len;
   logic [15:0] cur_words;
   logic        rx_last;
   logic [15:0] tx_words;
   logic        tx_last;
   logic [15:0] csum_fixed;
   logic        csum_bad;
   logic        wr_en;
   logic [AW-1:0] rd_addr;
   logic [15:0] rd_data;

   // Datapath decode: the first received word decides the drop, later words reuse the latch
   always_comb begin
      rx_acc     = (state == RX) && ip_wb_ack_i && !ip_wb_rty_i;
      tx_acc     = (state == TX) && ip_wb_ack_i && !ip_wb_rty_i;
      first_word = (wcnt == 16'd0);
      cur_len    = first_word ? rx_length_i : len_q;
      cur_words  = {1'b0, cur_len[15:1]} + {15'd0, cur_len[0]};
      rx_last    = (wcnt + 16'd1) >= cur_words;
      bad_meta   = (rx_protocol_i != ICMP_PROTO) || (rx_dest_ip_i != LOCAL_IP) ||
                   (rx_length_i < 16'd8) || (rx_length_i > 16'(2 * BUF_WORDS)) ||
                   (ip_wb_dat_i[7:0] != ICMP_ECHO_REQ) || (ip_wb_dat_i[15:8] != 8'd0);
      drop_now   = first_word ? bad_meta : drop_q;
      wr_en      = rx_acc && !drop_now;
      tx_words   = {1'b0, len_q[15:1]} + {15'd0, len_q[0]};
      tx_last    = (ridx + 16'd1) >= tx_words;
      // Read one word ahead so rd_data already holds buf[ridx] when ridx advances
      rd_addr    = tx_acc ? ridx[AW-1:0] + AW'(1) : ridx[AW-1:0];
      csum_fixed = oc_add16(swap16(w1_q), 16'h0800);
      if (csum_fixed == 16'hFFFF) begin
         csum_fixed = 16'h0000;
      end
   end

   // Words 0 and 1 are rewritten, so they are served from registers instead of the RAM
   always_comb begin
      if (ridx == 16'd0) begin
         ip_wb_dat_o = w0_q;
      end else if (ridx == 16'd1) begin
         ip_wb_dat_o = w1_q;
      end else begin
         ip_wb_dat_o = rd_data;
      end
   end

`ifdef ICMP_CSUM_VERIFY_EN
   logic [15:0] sum_q;
   logic [15:0] rx_word_net;

   // Zero-pad the unused high byte of an odd-length tail before summing
   always_comb begin
      rx_word_net = ip_wb_dat_i;
      if (rx_last && cur_len[0]) begin
         rx_word_net[15:8] = 8'd0;
      end
      rx_word_net = swap16(rx_word_net);
      csum_bad    = (sum_q != 16'hFFFF);
   end

   // Running ones-complement sum of the received message
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sum_q <= 16'd0;
      end else if (rx_acc) begin
         sum_q <= oc_add16(first_word ? 16'd0 : sum_q, rx_word_net);
      end
   end
`else
   assign csum_bad = 1'b0;
`endif

   icmp_echo_buf #(
      .BUF_WORDS (BUF_WORDS),
      .AW        (AW)
   ) u_buf (
      .wb_clk_i (wb_clk_i),
      .wr_en    (wr_en),
      .wr_addr  (wcnt[AW-1:0]),
      .wr_data  (ip_wb_dat_i),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
   );

   // Transaction sequencer with registered bus, metadata and counter outputs
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state         <= IDLE;
         ip_wb_cyc_o   <= 1'b0;
         ip_wb_stb_o   <= 1'b0;
         ip_wb_we_o    <= 1'b0;
         tx_src_ip_o   <= 32'd0;
         tx_dest_ip_o  <= 32'd0;
         tx_protocol_o <= 8'd0;
         tx_length_o   <= 16'd0;
         rx_count_o    <= 16'd0;
         tx_count_o    <= 16'd0;
         drop_count_o  <= 16'd0;
         wcnt          <= 16'd0;
         ridx          <= 16'd0;
         len_q         <= 16'd0;
         src_q         <= 32'd0;
         drop_q        <= 1'b0;
         w0_q          <= 16'd0;
         w1_q          <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               wcnt   <= 16'd0;
               drop_q <= 1'b0;
               if (enable_i) begin
                  ip_wb_cyc_o <= 1'b1;
                  ip_wb_stb_o <= 1'b1;
                  ip_wb_we_o  <= 1'b0;
                  state       <= RX;
               end
            end
            RX: begin
               if (ip_wb_rty_i) begin
                  ip_wb_cyc_o  <= 1'b0;
                  ip_wb_stb_o  <= 1'b0;
                  drop_count_o <= sat_inc16(drop_count_o);
                  state        <= IDLE;
               end else if (ip_wb_ack_i) begin
                  if (first_word) begin
                     len_q  <= rx_length_i;
                     src_q  <= rx_src_ip_i;
                     drop_q <= bad_meta;
                     w0_q   <= ip_wb_dat_i;
                  end
                  if (wcnt == 16'd1) begin
                     w1_q <= ip_wb_dat_i;
                  end
                  wcnt <= wcnt + 16'd1;
                  if (rx_last) begin
                     ip_wb_cyc_o <= 1'b0;
                     ip_wb_stb_o <= 1'b0;
                     state       <= RX_GAP;
                  end
               end
            end
            RX_GAP: begin
               ridx <= 16'd0;
               if (drop_q || csum_bad) begin
                  drop_count_o <= sat_inc16(drop_count_o);
                  state        <= IDLE;
               end else begin
                  state <= FIX;
               end
            end
            FIX: begin
               w0_q          <= {w0_q[15:8], ICMP_ECHO_REPLY};
               w1_q          <= swap16(csum_fixed);
               rx_count_o    <= sat_inc16(rx_count_o);
               tx_src_ip_o   <= LOCAL_IP;
               tx_dest_ip_o  <= src_q;
               tx_protocol_o <= ICMP_PROTO;
               tx_length_o   <= len_q;
               ip_wb_cyc_o   <= 1'b1;
               ip_wb_stb_o   <= 1'b1;
               ip_wb_we_o    <= 1'b1;
               state         <= TX;
            end
            TX: begin
               if (ip_wb_rty_i) begin
                  ip_wb_cyc_o  <= 1'b0;
                  ip_wb_stb_o  <= 1'b0;
                  ip_wb_we_o   <= 1'b0;
                  drop_count_o <= sat_inc16(drop_count_o);
                  state        <= IDLE;
               end else if (ip_wb_ack_i) begin
                  ridx <= ridx + 16'd1;
                  if (tx_last) begin
                     ip_wb_cyc_o <= 1'b0;
                     ip_wb_stb_o <= 1'b0;
                     ip_wb_we_o  <= 1'b0;
                     tx_count_o  <= sat_inc16(tx_count_o);
                     state       <= TX_GAP;
                  end
               end
            end
            TX_GAP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icmp_echo_responder.sv
// tb/tb_icmp_echo_responder.sv - randomized self-checking bench with an IP-layer stand-in and reply model
module tb_icmp_echo_responder;

   localparam logic [31:0] LOCAL_IP = 32'hC0A8_0102;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        enable_i = 1'b0;
   logic        ip_wb_cyc_o, ip_wb_stb_o, ip_wb_we_o;
   logic        ip_wb_ack_i = 1'b0;
   logic        ip_wb_rty_i = 1'b0;
   logic [15:0] ip_wb_dat_o;
   logic [15:0] ip_wb_dat_i = 16'd0;
   logic [31:0] rx_src_ip_i = 32'd0;
   logic [31:0] rx_dest_ip_i = 32'd0;
   logic [7:0]  rx_protocol_i = 8'd0;
   logic [15:0] rx_length_i = 16'd0;
   logic [31:0] tx_src_ip_o, tx_dest_ip_o;
   logic [7:0]  tx_protocol_o;
   logic [15:0] tx_length_o, rx_count_o, tx_count_o, drop_count_o;

   always #5 wb_clk_i = ~wb_clk_i;

   icmp_echo_responder dut (
      .wb_clk_i      (wb_clk_i),
      .wb_rst_i      (wb_rst_i),
      .enable_i      (enable_i),
      .ip_wb_cyc_o   (ip_wb_cyc_o),
      .ip_wb_stb_o   (ip_wb_stb_o),
      .ip_wb_we_o    (ip_wb_we_o),
      .ip_wb_ack_i   (ip_wb_ack_i),
      .ip_wb_rty_i   (ip_wb_rty_i),
      .ip_wb_dat_o   (ip_wb_dat_o),
      .ip_wb_dat_i   (ip_wb_dat_i),
      .rx_src_ip_i   (rx_src_ip_i),
      .rx_dest_ip_i  (rx_dest_ip_i),
      .rx_protocol_i (rx_protocol_i),
      .rx_length_i   (rx_length_i),
      .tx_src_ip_o   (tx_src_ip_o),
      .tx_dest_ip_o  (tx_dest_ip_o),
      .tx_protocol_o (tx_protocol_o),
      .tx_length_o   (tx_length_o),
      .rx_count_o    (rx_count_o),
      .tx_count_o    (tx_count_o),
      .drop_count_o  (drop_count_o)
   );

   int errors = 0;
   int checks = 0;
   int m_rx = 0;
   int m_tx = 0;
   int m_drop = 0;
   logic [7:0]  pkt [0:1199];
   logic [15:0] cap [0:299];
   int cap_n;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Ones-complement sum over len bytes in network order, odd tail zero-padded
   function automatic int oc_sum(input int len);
      int s;
      s = 0;
      for (int i = 0; i < len; i += 2) begin
         s += {pkt[i], (i + 1 < len) ? pkt[i + 1] : 8'h00};
      end
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      return s;
   endfunction

   task automatic set_csum(input int len);
      int s;
      pkt[2] = 8'h00;
      pkt[3] = 8'h00;
      s = ~oc_sum(len) & 32'hFFFF;
      pkt[2] = s[15:8];
      pkt[3] = s[7:0];
   endtask

   task automatic build_req(input int len);
      pkt[0] = 8'd8;
      pkt[1] = 8'd0;
      for (int i = 4; i <= len; i++) pkt[i] = 8'($urandom);
      set_csum(len);
   endtask

   // Reply word i in bus order: type cleared, checksum raised by 0x0800 with end-around carry
   function automatic logic [15:0] exp_word(input int i);
      int c;
      if (i == 0) return {pkt[1], 8'h00};
      if (i == 1) begin
         c = {16'd0, pkt[2], pkt[3]} + 32'h0800;
         if (c > 32'hFFFF) c -= 32'hFFFF;
         if (c == 32'hFFFF) c = 0;
         return {c[7:0], c[15:8]};
      end
      return {pkt[2 * i + 1], pkt[2 * i]};
   endfunction

   // rty_mode: 0 none, 1 abort during receive, 2 abort during transmit
   task automatic run_packet(input logic [31:0] src, input logic [31:0] dest,
                             input logic [7:0] proto, input int len,
                             input int rty_mode, input int rty_at);
      int  nwords;
      int  to;
      bit  accept;
      bit  aborted;
      nwords  = (len + 1) / 2;
      aborted = 1'b0;
      cap_n   = 0;
      accept  = (proto == 8'd1) && (dest == LOCAL_IP) && (len >= 8) && (len <= 512) &&
                (pkt[0] == 8'd8) && (pkt[1] == 8'd0) && (rty_mode != 1);
`ifdef ICMP_CSUM_VERIFY_EN
      accept = accept && (oc_sum(len) == 32'hFFFF);
`endif
      rx_src_ip_i   = src;
      rx_dest_ip_i  = dest;
      rx_protocol_i = proto;
      rx_length_i   = 16'(len);
      enable_i      = 1'b1;
      to = 0;
      while (!(ip_wb_cyc_o && !ip_wb_we_o) && to < 50) begin
         @(negedge wb_clk_i);
         to++;
      end
      chk("rx_start", 32'(ip_wb_cyc_o && !ip_wb_we_o), 32'd1);
      for (int i = 0; i < nwords; i++) begin
         ip_wb_ack_i = 1'b0;
         if ($urandom_range(0, 3) == 0) @(negedge wb_clk_i);
         if (rty_mode == 1 && i == rty_at) begin
            ip_wb_rty_i = 1'b1;
            @(negedge wb_clk_i);
            ip_wb_rty_i = 1'b0;
            enable_i    = 1'b0;
            chk("rty_rx_cyc", 32'(ip_wb_cyc_o), 32'd0);
            m_drop++;
            aborted = 1'b1;
            break;
         end
         chk("rx_bus", 32'({ip_wb_cyc_o, ip_wb_stb_o, ip_wb_we_o}), 32'b110);
         ip_wb_ack_i = 1'b1;
         ip_wb_dat_i = {pkt[2 * i + 1], pkt[2 * i]};
         @(negedge wb_clk_i);
      end
      ip_wb_ack_i = 1'b0;
      if (!aborted) begin
         enable_i = 1'b0;
         chk("rx_end_cyc", 32'(ip_wb_cyc_o), 32'd0);
         if (!accept) begin
            m_drop++;
            for (int k = 0; k < 4; k++) begin
               @(negedge wb_clk_i);
               chk("drop_no_tx", 32'(ip_wb_cyc_o), 32'd0);
            end
         end else begin
            to = 0;
            while (!(ip_wb_cyc_o && ip_wb_we_o) && to < 20) begin
               @(negedge wb_clk_i);
               to++;
            end
            chk("tx_start", 32'(ip_wb_cyc_o && ip_wb_we_o && ip_wb_stb_o), 32'd1);
            m_rx++;
            repeat ($urandom_range(0, 4)) @(negedge wb_clk_i);
            for (int i = 0; i < nwords; i++) begin
               ip_wb_ack_i = 1'b0;
               if ($urandom_range(0, 2) == 0) @(negedge wb_clk_i);
               if (rty_mode == 2 && i == rty_at) begin
                  ip_wb_rty_i = 1'b1;
                  @(negedge wb_clk_i);
                  ip_wb_rty_i = 1'b0;
                  chk("rty_tx_cyc", 32'(ip_wb_cyc_o), 32'd0);
                  m_drop++;
                  aborted = 1'b1;
                  break;
               end
               chk("tx_dat", 32'(ip_wb_dat_o), 32'(exp_word(i)));
               chk("tx_src", tx_src_ip_o, LOCAL_IP);
               chk("tx_dest", tx_dest_ip_o, src);
               chk("tx_meta", 32'({tx_protocol_o, tx_length_o}), 32'({8'd1, 16'(len)}));
               cap[i] = ip_wb_dat_o;
               cap_n  = i + 1;
               ip_wb_ack_i = 1'b1;
               @(negedge wb_clk_i);
            end
            ip_wb_ack_i = 1'b0;
            if (!aborted) begin
               chk("tx_end_cyc", 32'(ip_wb_cyc_o), 32'd0);
               m_tx++;
            end
         end
      end
      repeat (3) @(negedge wb_clk_i);
      chk("rx_count", 32'(rx_count_o), 32'(m_rx));
      chk("tx_count", 32'(tx_count_o), 32'(m_tx));
      chk("drop_count", 32'(drop_count_o), 32'(m_drop));
   endtask

   initial begin
      int len, f, rmode, rat;
      logic [31:0] dest;
      logic [7:0]  proto;
      repeat (3) @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
      chk("rst_bus", 32'({ip_wb_cyc_o, ip_wb_stb_o, ip_wb_we_o}), 32'd0);
      chk("rst_tx_ip", tx_src_ip_o | tx_dest_ip_o, 32'd0);
      chk("rst_tx_meta", 32'({tx_protocol_o, tx_length_o}), 32'd0);
      chk("rst_counts", 32'(rx_count_o | tx_count_o | drop_count_o), 32'd0);

      // Reset in the middle of a receive
      build_req(64);
      rx_protocol_i = 8'd1; rx_dest_ip_i = LOCAL_IP; rx_length_i = 16'd64;
      enable_i = 1'b1;
      @(negedge wb_clk_i);
      @(negedge wb_clk_i);
      ip_wb_ack_i = 1'b1; ip_wb_dat_i = {pkt[1], pkt[0]};
      @(negedge wb_clk_i);
      ip_wb_ack_i = 1'b0; enable_i = 1'b0; wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      chk("midrst_cyc", 32'(ip_wb_cyc_o), 32'd0);
      @(negedge wb_clk_i);
      chk("midrst_counts", 32'(rx_count_o | tx_count_o | drop_count_o), 32'd0);

      // 64-byte ping whose checksum is F7FD
      for (int i = 0; i < 65; i++) pkt[i] = 8'd0;
      pkt[0] = 8'd8; pkt[7] = 8'd2;
      set_csum(64);
      run_packet(32'h0A00_0001, LOCAL_IP, 8'd1, 64, 0, 0);
      chk("ping_words", 32'(cap_n), 32'd32);
      chk("ping_w0", 32'(cap[0]), 32'h0000);
      chk("ping_csum", 32'({cap[1][7:0], cap[1][15:8]}), 32'hFFFD);
      chk("ping_dest", tx_dest_ip_o, 32'h0A00_0001);
      chk("ping_txcnt", 32'(tx_count_o), 32'd1);

      build_req(20);
      run_packet(32'h0A00_0002, LOCAL_IP, 8'd17, 20, 0, 0);
      chk("udp_drop", 32'(drop_count_o), 32'd1);
      build_req(40);
      run_packet(32'h0A00_0003, LOCAL_IP + 32'd1, 8'd1, 40, 0, 0);
      build_req(600);
      run_packet(32'h0A00_0004, LOCAL_IP, 8'd1, 600, 0, 0);
      build_req(9);
      run_packet(32'h0A00_0005, LOCAL_IP, 8'd1, 9, 0, 0);
      chk("odd_words", 32'(cap_n), 32'd5);
      chk("odd_len", 32'(tx_length_o), 32'd9);
      build_req(32);
      run_packet(32'h0A00_0006, LOCAL_IP, 8'd1, 32, 2, 0);
      build_req(32);
      run_packet(32'h0A00_0007, LOCAL_IP, 8'd1, 32, 0, 0);
      build_req(30);
      pkt[3] = pkt[3] ^ 8'h55;
      run_packet(32'h0A00_0008, LOCAL_IP, 8'd1, 30, 0, 0);

      for (int n = 0; n < 25; n++) begin
         len = $urandom_range(8, 120);
         build_req(len);
         dest = LOCAL_IP; proto = 8'd1; rmode = 0; rat = 0;
         f = $urandom_range(0, 11);
         case (f)
            0: proto = 8'd6;
            1: dest = LOCAL_IP ^ (32'd1 << $urandom_range(0, 31));
            2: begin len = $urandom_range(2, 7); build_req(len); end
            3: pkt[0] = 8'd0;
            4: pkt[1] = 8'($urandom_range(1, 255));
            5: begin rmode = 1; rat = $urandom_range(0, (len + 1) / 2 - 1); end
            6: begin rmode = 2; rat = $urandom_range(0, (len + 1) / 2 - 1); end
            7: pkt[2] = pkt[2] ^ 8'h10;
            default: ;
         endcase
         run_packet($urandom, dest, proto, len, rmode, rat);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
